pin_change_irq_c: RTL and testbench

PIN_CHANGE_IRQ_C -- requirements
Module: pin_change_irq_c

---
 rtl/pin_change_irq_c.sv | 103 ++++++++++
 tb/tb_pin_change_irq_c.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pin_change_irq_c.sv
// Pin-change interrupt block for port C: PCICR/PCMSK1 in data memory, PCIFR in I/O space,
// with a two-flop synchronizer and edge detector feeding a sticky pending flag PCIF1.
module pin_change_irq_c #(
  parameter logic [7:0] PCICR_Address  = 8'h68,
  parameter logic [7:0] PCMSK1_Address = 8'h6C,
  parameter logic [5:0] PCIFR_Address  = 6'h1B
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic       io_out_en,
  output logic [7:0] io_dbus_out,
  output logic       dm_out_en,
  output logic [7:0] dm_dbus_out,
  input  logic [6:0] pinC_i,
  output logic [6:0] PCINT,
  output logic       PCIE1,
  output logic       pcint1_irq,
  input  logic       pcint1_ack
);

  logic       r_pcie1;
  logic [6:0] r_pcmsk1;
  logic       r_pcif1;
  logic [6:0] r_s1;
  logic [6:0] r_s2;
  logic [6:0] r_prev;

  logic       w_pcicr_sel;
  logic       w_pcmsk1_sel;
  logic       w_pcifr_sel;
  logic [6:0] w_change;
  logic       w_set;
  logic       w_clr;

  assign w_pcicr_sel  = (ramadr == PCICR_Address);
  assign w_pcmsk1_sel = (ramadr == PCMSK1_Address);
  assign w_pcifr_sel  = (IO_Addr == PCIFR_Address);

  assign w_change = (r_s2 ^ r_prev) & r_pcmsk1;
  assign w_set    = |w_change;
  assign w_clr    = (iowe & w_pcifr_sel & dbus_in[1]) | pcint1_ack;

  // Configuration registers
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_pcie1  <= 1'b0;
      r_pcmsk1 <= 7'h00;
    end else begin
      if (ramwe && w_pcicr_sel)
        r_pcie1 <= dbus_in[1];
      if (ramwe && w_pcmsk1_sel)
        r_pcmsk1 <= dbus_in[6:0];
    end
  end

  // Synchronizer and previous-sample stage for edge detection
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      r_s1   <= 7'h00;
      r_s2   <= 7'h00;
      r_prev <= 7'h00;
    end else begin
      r_s1   <= pinC_i;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Pending flag: a new change event beats a simultaneous clear so no edge is lost
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset)
      r_pcif1 <= 1'b0;
    else if (w_set)
      r_pcif1 <= 1'b1;
    else if (w_clr)
      r_pcif1 <= 1'b0;
  end

  assign PCINT      = r_pcmsk1;
  assign PCIE1      = r_pcie1;
  assign pcint1_irq = r_pcif1 & r_pcie1;

  assign io_out_en   = iore & w_pcifr_sel;
  assign io_dbus_out = io_out_en ? {6'b0, r_pcif1, 1'b0} : 8'h00;

  assign dm_out_en = ramre & (w_pcicr_sel | w_pcmsk1_sel);

  always_comb begin
    dm_dbus_out = 8'h00;
    if (ramre && w_pcicr_sel)
      dm_dbus_out = {6'b0, r_pcie1, 1'b0};
    else if (ramre && w_pcmsk1_sel)
      dm_dbus_out = {1'b0, r_pcmsk1};
  end

endmodule

// File: tb/tb_pin_change_irq_c.sv
// Directed bench for pin_change_irq_c: register access table plus hand-written
// sequences for detection latency, clearing, set/clear collisions and async reset.
module tb_pin_change_irq_c;

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] ramadr;
  logic       ramre, ramwe;
  logic [7:0] dbus_in;
  logic       io_out_en;
  logic [7:0] io_dbus_out;
  logic       dm_out_en;
  logic [7:0] dm_dbus_out;
  logic [6:0] pinC_i;
  logic [6:0] PCINT;
  logic       PCIE1;
  logic       pcint1_irq;
  logic       pcint1_ack;

  int checks = 0;
  int errors = 0;

  pin_change_irq_c dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .io_out_en(io_out_en), .io_dbus_out(io_dbus_out),
    .dm_out_en(dm_out_en), .dm_dbus_out(dm_dbus_out),
    .pinC_i(pinC_i), .PCINT(PCINT), .PCIE1(PCIE1),
    .pcint1_irq(pcint1_irq), .pcint1_ack(pcint1_ack)
  );

  always #5 cp2 = ~cp2;

  typedef struct {
    bit         io;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    bit         exp_en;
    logic [6:0] exp_pcint;
    bit         exp_pcie1;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp2);
    #1;
  endtask

  task automatic dm_write(input logic [7:0] a, input logic [7:0] d);
    ramadr = a; dbus_in = d; ramwe = 1'b1;
    tick();
    ramwe = 1'b0;
  endtask

  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    tick();
    iowe = 1'b0;
  endtask

  task automatic dm_read(input logic [7:0] a, output logic [7:0] d, output logic en);
    ramadr = a; ramre = 1'b1;
    #1;
    d = dm_dbus_out; en = dm_out_en;
    ramre = 1'b0;
  endtask

  task automatic check_flag(input string name, input logic exp);
    IO_Addr = 6'h1B; iore = 1'b1;
    #1;
    check(name, {24'b0, io_dbus_out}, {30'b0, exp, 1'b0});
    iore = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       en;

    vecs[0]  = '{0, 0, 8'h68, 8'h00, 8'h00, 1, 7'h00, 0};
    vecs[1]  = '{0, 0, 8'h6C, 8'h00, 8'h00, 1, 7'h00, 0};
    vecs[2]  = '{1, 0, 8'h1B, 8'h00, 8'h00, 1, 7'h00, 0};
    vecs[3]  = '{0, 0, 8'h50, 8'h00, 8'h00, 0, 7'h00, 0};
    vecs[4]  = '{1, 0, 8'h1C, 8'h00, 8'h00, 0, 7'h00, 0};
    vecs[5]  = '{0, 1, 8'h68, 8'hFF, 8'h02, 1, 7'h00, 1};
    vecs[6]  = '{0, 1, 8'h6C, 8'hFF, 8'h7F, 1, 7'h7F, 1};
    vecs[7]  = '{0, 1, 8'h6C, 8'h04, 8'h04, 1, 7'h04, 1};
    vecs[8]  = '{0, 1, 8'h68, 8'h00, 8'h00, 1, 7'h04, 0};
    vecs[9]  = '{1, 1, 8'h1B, 8'hFF, 8'h00, 1, 7'h04, 0};
    vecs[10] = '{0, 1, 8'h68, 8'h02, 8'h02, 1, 7'h04, 1};
    vecs[11] = '{0, 1, 8'h50, 8'hFF, 8'h00, 0, 7'h04, 1};

    ireset = 1'b1; IO_Addr = '0; iore = 0; iowe = 0; ramadr = '0; ramre = 0; ramwe = 0;
    dbus_in = '0; pinC_i = '0; pcint1_ack = 0;
    tick(); tick();
    check("rst_irq", {31'b0, pcint1_irq}, 0);
    check("rst_pcint", {25'b0, PCINT}, 0);
    check("rst_pcie1", {31'b0, PCIE1}, 0);
    ireset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) begin
        if (vecs[i].io) io_write(vecs[i].addr[5:0], vecs[i].wdata);
        else            dm_write(vecs[i].addr, vecs[i].wdata);
      end
      if (vecs[i].io) begin
        IO_Addr = vecs[i].addr[5:0]; iore = 1'b1;
        #1;
        rd = io_dbus_out; en = io_out_en;
        iore = 1'b0;
      end else begin
        dm_read(vecs[i].addr, rd, en);
      end
      check($sformatf("vec%0d_rd", i), {24'b0, rd}, {24'b0, vecs[i].exp_rd});
      check($sformatf("vec%0d_en", i), {31'b0, en}, {31'b0, vecs[i].exp_en});
      check($sformatf("vec%0d_pcint", i), {25'b0, PCINT}, {25'b0, vecs[i].exp_pcint});
      check($sformatf("vec%0d_pcie1", i), {31'b0, PCIE1}, {31'b0, vecs[i].exp_pcie1});
    end

    // Detection latency: PCMSK1=04, PCICR=02 from the table
    pinC_i[2] = 1'b1;
    tick();
    check_flag("lat_k", 0);
    tick();
    check_flag("lat_k1", 0);
    tick();
    check_flag("lat_k2", 1);
    check("lat_irq", {31'b0, pcint1_irq}, 1);

    // Write-0 leaves flag, write-1 clears it
    io_write(6'h1B, 8'h00);
    check_flag("w0_keep", 1);
    io_write(6'h1B, 8'h02);
    check_flag("w1_clr", 0);
    check("w1_irq", {31'b0, pcint1_irq}, 0);

    // Masked pin has no effect
    pinC_i[3] = 1'b1;
    tick(); tick(); tick(); tick();
    check_flag("masked", 0);
    dm_read(8'h6C, rd, en);
    check("masked_rd", {24'b0, rd}, 32'h04);
    check("masked_pcint", {25'b0, PCINT}, 32'h04);

    // Set coincides with ack: set wins, then a lone ack clears
    pinC_i[2] = 1'b0;
    tick(); tick();
    pcint1_ack = 1'b1;
    tick();
    pcint1_ack = 1'b0;
    check_flag("ack_coll", 1);
    pcint1_ack = 1'b1;
    tick();
    pcint1_ack = 1'b0;
    check_flag("ack_clr", 0);

    // Set coincides with write-1 clear: set wins
    pinC_i[2] = 1'b1;
    tick(); tick();
    io_write(6'h1B, 8'h02);
    check_flag("w1_coll", 1);
    io_write(6'h1B, 8'h02);
    check_flag("w1_coll_clr", 0);

    // Pending flag with interrupt disabled, then enable
    dm_write(8'h68, 8'h00);
    pinC_i[2] = 1'b0;
    tick(); tick(); tick();
    check_flag("pend_flag", 1);
    check("pend_irq0", {31'b0, pcint1_irq}, 0);
    dm_write(8'h68, 8'h02);
    check("pend_irq1", {31'b0, pcint1_irq}, 1);

    // Async reset between edges
    #2;
    ireset = 1'b1;
    #1;
    check("arst_irq", {31'b0, pcint1_irq}, 0);
    check("arst_pcint", {25'b0, PCINT}, 0);
    check("arst_pcie1", {31'b0, PCIE1}, 0);
    check_flag("arst_flag", 0);
    dm_read(8'h68, rd, en);
    check("arst_pcicr", {24'b0, rd}, 0);
    dm_read(8'h6C, rd, en);
    check("arst_pcmsk1", {24'b0, rd}, 0);
    tick();
    ireset = 1'b0;
    pinC_i = 7'h7F;
    tick(); tick(); tick(); tick();
    check_flag("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
